// File: rtl/serial_adder.sv
// serial_adder: multi-cycle a+b+cin, DIGIT bits per cycle LSB first, with start/done handshake
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d, ps_next;
  logic carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGIT:0] dsum;
  logic last;
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign ps_next = WIDTH'({dsum[DIGIT-1:0], ps_q} >> DIGIT);
  assign last = cnt_q == CW'(STEPS - 1);
  assign ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign overflow = ovf_q;
  // next state: latch operands on accept, ripple one digit per RUN cycle, publish result on the last digit
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ps_d = ps_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d = a;
        b_d = b;
        carry_d = cin;
        a_msb_d = a[WIDTH-1];
        b_msb_d = b[WIDTH-1];
        cnt_d = '0;
        ps_d = '0;
        state_d = RUN;
      end
    end else begin
      ps_d = ps_next;
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      carry_d = dsum[DIGIT];
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        sum_d = ps_next;
        cout_d = dsum[DIGIT];
        ovf_d = (a_msb_q == b_msb_q) && (ps_next[WIDTH-1] != a_msb_q);
        done_d = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end
    end
  end
  // state and datapath registers, all cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ps_q <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ps_q <= ps_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector and protocol checks over several WIDTH/DIGIT configurations
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       start_v [5];
  logic [7:0] a_v [5];
  logic [7:0] b_v [5];
  logic       cin_v [5];
  logic       ready_v [5];
  logic       busy_v [5];
  logic       done_v [5];
  logic [7:0] sum_v [5];
  logic       cout_v [5];
  logic       ovf_v [5];
  logic [1:0] s2;
  logic [3:0] s4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .overflow(ovf_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (.clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .overflow(ovf_v[2]));
  serial_adder #(.WIDTH(2), .DIGIT(1)) u21 (.clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3][1:0]), .b(b_v[3][1:0]), .cin(cin_v[3]),
    .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .sum(s2), .cout(cout_v[3]), .overflow(ovf_v[3]));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst(rst), .start(start_v[4]), .a(a_v[4][3:0]), .b(b_v[4][3:0]), .cin(cin_v[4]),
    .ready(ready_v[4]), .busy(busy_v[4]), .done(done_v[4]), .sum(s4), .cout(cout_v[4]), .overflow(ovf_v[4]));

  assign sum_v[3] = {6'b0, s2};
  assign sum_v[4] = {4'b0, s4};

  typedef struct {
    int idx;
    int steps;
    logic [7:0] a;
    logic [7:0] b;
    logic c;
    logic [7:0] s;
    logic co;
    logic ov;
    int pulse;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int i, input int steps, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [7:0] es, input logic ec, input logic eo, input int pulse, input string nm);
    int j;
    int bc;
    logic [7:0] prev;
    logic held;
    @(negedge clk);
    a_v[i] = av;
    b_v[i] = bv;
    cin_v[i] = cv;
    start_v[i] = 1'b1;
    prev = sum_v[i];
    held = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    j = 0;
    bc = 0;
    while (!done_v[i] && j < steps + 4) begin
      bc += int'(busy_v[i]);
      if (sum_v[i] !== prev) held = 1'b0;
      if (j == pulse) begin
        start_v[i] = 1'b1;
        a_v[i] = 8'h5A;
        b_v[i] = 8'hA5;
        cin_v[i] = 1'b1;
      end else start_v[i] = 1'b0;
      @(negedge clk);
      j++;
    end
    start_v[i] = 1'b0;
    chk($sformatf("%s_latency", nm), j, steps);
    chk($sformatf("%s_busycycles", nm), bc, steps);
    chk($sformatf("%s_sumheld", nm), held, 1);
    chk($sformatf("%s_ready", nm), ready_v[i], 1);
    chk($sformatf("%s_sum", nm), sum_v[i], es);
    chk($sformatf("%s_cout", nm), cout_v[i], ec);
    chk($sformatf("%s_ovf", nm), ovf_v[i], eo);
    @(negedge clk);
    chk($sformatf("%s_doneclr", nm), done_v[i], 0);
  endtask

  initial begin
    int j;
    logic seen;
    for (int i = 0; i < 5; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      cin_v[i] = 1'b0;
    end
    tv[0]  = '{0, 8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1};
    tv[1]  = '{0, 8, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1};
    tv[2]  = '{0, 8, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1};
    tv[3]  = '{0, 8, 8'h3C, 8'hC5, 1'b1, 8'h02, 1'b1, 1'b0, -1};
    tv[4]  = '{0, 8, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3};
    tv[5]  = '{0, 8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, -1};
    tv[6]  = '{0, 8, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, -1};
    tv[7]  = '{0, 8, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, -1};
    tv[8]  = '{1, 2, 8'h3C, 8'hC5, 1'b1, 8'h02, 1'b1, 1'b0, -1};
    tv[9]  = '{2, 1, 8'h3C, 8'hC5, 1'b1, 8'h02, 1'b1, 1'b0, -1};
    tv[10] = '{1, 2, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 0};
    #1;
    chk("rst_sum", sum_v[0], 0);
    chk("rst_cout", cout_v[0], 0);
    chk("rst_ovf", ovf_v[0], 0);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_ready%0d", i), ready_v[i], 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 11; k++)
      run(tv[k].idx, tv[k].steps, tv[k].a, tv[k].b, tv[k].c, tv[k].s, tv[k].co, tv[k].ov, tv[k].pulse, $sformatf("vec%0d", k));
    @(negedge clk);
    a_v[0] = 8'h12;
    b_v[0] = 8'h34;
    cin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    a_v[0] = 8'h80;
    b_v[0] = 8'hFF;
    j = 0;
    while (!done_v[0] && j < 12) begin
      @(negedge clk);
      j++;
    end
    chk("b2b_lat1", j, 8);
    chk("b2b_sum1", sum_v[0], 8'h46);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_doneclr", done_v[0], 0);
    chk("b2b_busy", busy_v[0], 1);
    chk("b2b_hold", sum_v[0], 8'h46);
    j = 1;
    while (!done_v[0] && j < 14) begin
      @(negedge clk);
      j++;
    end
    chk("b2b_lat2", j, 9);
    chk("b2b_sum2", sum_v[0], 8'h7F);
    chk("b2b_cout2", cout_v[0], 1);
    chk("b2b_ovf2", ovf_v[0], 1);
    repeat (3) @(negedge clk);
    chk("idle_hold", sum_v[0], 8'h7F);
    a_v[0] = 8'h01;
    b_v[0] = 8'h01;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_sum", sum_v[0], 0);
    chk("mrst_cout", cout_v[0], 0);
    chk("mrst_ovf", ovf_v[0], 0);
    chk("mrst_busy", busy_v[0], 0);
    chk("mrst_ready", ready_v[0], 1);
    chk("mrst_done", done_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) seen = 1'b1;
    end
    chk("mrst_nodone", seen, 0);
    run(0, 8, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, -1, "post_rst");
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          int full, ss;
          full = x + y + c;
          ss = (x >= 2 ? x - 4 : x) + (y >= 2 ? y - 4 : y) + c;
          run(3, 2, 8'(x), 8'(y), 1'(c), 8'(full % 4), 1'(full / 4), (ss > 1 || ss < -2), -1, "ex2");
        end
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          int full, ss;
          full = x + y + c;
          ss = (x >= 8 ? x - 16 : x) + (y >= 8 ? y - 16 : y) + c;
          run(4, 2, 8'(x), 8'(y), 1'(c), 8'(full % 16), 1'(full / 16), (ss > 7 || ss < -8), -1, "ex4");
        end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder computing sum = a + b + cin over WIDTH bits, processing DIGIT bits per clock cycle, least-significant digit first, through a narrow ripple slice. It succeeds the single-bit combinational full adder as the reusable arithmetic block for area-constrained datapaths. It trades latency for area and uses a start/done handshake so a sequencer can issue operations back to back. Signed overflow is reported alongside carry-out.

## Interface
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- DIGIT, 1, bits added per cycle; must be >= 1 and divide WIDTH exactly. STEPS = WIDTH/DIGIT.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; accepted only on an edge where ready=1.
- a  input  WIDTH  operand A; sampled on the accept edge only.
- b  input  WIDTH  operand B; sampled on the accept edge only.
- cin  input  1  carry-in; sampled on the accept edge only.
- ready  output  1  high in IDLE; equals ~busy.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result registers updated on the preceding edge.
- sum  output  WIDTH  result, low WIDTH bits of a+b+cin.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

## Operation
- States: IDLE and RUN. Internal registers: operand shift registers (A, B), partial-sum shift register, running carry, digit counter (0..STEPS-1).
- IDLE with start=1 at an edge: latch a, b, and cin (into carry); clear counter and partial sum; go to RUN. IDLE with start=0: hold.
- RUN, each edge: {c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - Shift s into the partial-sum MSB end; shift A and B right by DIGIT.
  - carry <= c; counter increments.
- RUN edge with counter == STEPS-1:
  - Write the completed sum into sum; write the final carry into cout; compute overflow from the latched operand MSBs and the final sum MSB.
  - Set done <= 1 and go to IDLE.
- done clears on the next edge.
- start while busy=1 is ignored; no queuing, and operands in flight are unaffected.
- sum, cout and overflow change only on completion edges. They hold their value until the next completion and do not change during RUN.
- WIDTH == DIGIT (STEPS = 1) is legal: a single RUN cycle.

## Timing
- Reset (async assert): state IDLE; ready=1, busy=0, done=0, sum=0, cout=0, overflow=0; counter, carry and shift registers are zero.
- Reset mid-operation abandons the operation. No done pulse follows, and the result registers read 0.
- Accept at edge N:
  - busy=1 from N to N+STEPS.
  - The completion edge is N+STEPS.
  - done=1, ready=1 and the new result are visible for exactly the cycle after edge N+STEPS.
  - Latency is STEPS cycles, measured from the accept edge to the result edge.
- Back to back: start=1 during the done cycle is accepted at that cycle's closing edge. done drops and busy rises on the same edge.
  - Maximum throughput is one result per STEPS+1 cycles.
- Carry wraps: a full-width add producing 2^WIDTH gives sum=0, cout=1.

## Test plan
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0.
  - Required: sum=8'h00, cout=1, overflow=0.
  - done pulses exactly 8 edges after accept; busy is high for 8 cycles.
- WIDTH=8, DIGIT=1, signed overflow:
  - a=8'h7F, b=8'h01, cin=0 requires sum=8'h80, cout=0, overflow=1.
  - a=8'h80, b=8'h80 requires sum=8'h00, cout=1, overflow=1.
- WIDTH=8, DIGIT=4: a=8'h3C, b=8'hC5, cin=1.
  - Required: sum=8'h02, cout=1, overflow=0, done 2 edges after accept.
  - Repeat with WIDTH=DIGIT=8: done 1 edge after accept.
- Protocol, WIDTH=8, DIGIT=1:
  - Pulse start with new operands mid-RUN: ignored, first result unchanged.
  - start held through the done cycle: second operation accepted, its done 9 cycles after the first done.
  - sum holds between completions.
- Reset mid-RUN after 3 digits: all outputs 0 immediately; no done pulse follows; the next operation completes correctly.
- Exhaustive check with WIDTH=2, DIGIT=1 and WIDTH=4, DIGIT=2: every a, b and cin value.
  - {cout, sum} equals a+b+cin.
  - overflow matches the signed reference.
